div_unit: RTL and testbench

Iterative 32-bit integer divider executing the RV32M DIV, DIVU, REM and REMU instructions. It sits in the execute stage beside the ALU and multiplier. It takes decoded operands and a 2-bit DIV opcode from the decoder, and delivers its result to write-back through the SEL_DIV source of the write-back mux. It uses a radix-2 restoring algorithm, one quotient bit per cycle, with valid/ready handshakes on both sides.

---
 rtl/div_unit.sv | 215 +++++++++++++++++++++
 tb/tb_div_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero, signed overflow and |a|<|b| skip the iteration.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] OP_UDIV = 2'd0;
  localparam logic [1:0] OP_SDIV = 2'd1;
  localparam logic [1:0] OP_UREM = 2'd2;
  localparam logic [1:0] OP_SREM = 2'd3;

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_r, next_state_s;
  logic [1:0]        op_r;
  logic [XLEN-1:0]   div_r;
  logic [XLEN-1:0]   quo_r;
  logic [XLEN:0]     rem_r;
  logic [4:0]        cnt_r;
  logic              sign_q_r, sign_r_r, div_zero_r;

  logic              accept_s, b_zero_s;
  logic [XLEN-1:0]   a_abs_s, b_abs_s;
  logic [XLEN:0]     rem_sh_s, rem_nx_s;
  logic [XLEN+1:0]   diff_s;
  logic [XLEN-1:0]   quo_nx_s, calc_res_s;
  logic              fast_s;
  logic [XLEN-1:0]   fast_res_s;

  assign ready_in = (state_r == IDLE);
  assign accept_s = valid_in && ready_in && !flush;
  assign b_zero_s = (b == {XLEN{1'b0}});

  // Operand magnitudes; only the signed ops take absolute values
  always_comb begin
    a_abs_s = a;
    b_abs_s = b;
    if (op[0] && a[XLEN-1]) begin
      a_abs_s = neg(a);
    end else begin
      a_abs_s = a;
    end
    if (op[0] && b[XLEN-1]) begin
      b_abs_s = neg(b);
    end else begin
      b_abs_s = b;
    end
  end

  // One restoring step: shift {rem, quo}, trial-subtract divisor, keep if non-negative
  always_comb begin
    rem_sh_s = {rem_r[XLEN-1:0], quo_r[XLEN-1]};
    diff_s   = {1'b0, rem_sh_s} - {2'b00, div_r};
    quo_nx_s = {quo_r[XLEN-2:0], ~diff_s[XLEN+1]};
    if (diff_s[XLEN+1]) begin
      rem_nx_s = rem_sh_s;
    end else begin
      rem_nx_s = diff_s[XLEN:0];
    end
  end

  // Final sign fixup; zero divisor yields all-ones quotient, which signed DIV must not negate
  always_comb begin
    calc_res_s = quo_nx_s;
    case (op_r)
      OP_UDIV: calc_res_s = quo_nx_s;
      OP_UREM: calc_res_s = rem_nx_s[XLEN-1:0];
      OP_SDIV: begin
        if (div_zero_r) begin
          calc_res_s = {XLEN{1'b1}};
        end else if (sign_q_r) begin
          calc_res_s = neg(quo_nx_s);
        end else begin
          calc_res_s = quo_nx_s;
        end
      end
      OP_SREM: begin
        if (sign_r_r) begin
          calc_res_s = neg(rem_nx_s[XLEN-1:0]);
        end else begin
          calc_res_s = rem_nx_s[XLEN-1:0];
        end
      end
      default: calc_res_s = quo_nx_s;
    endcase
  end

`ifdef DIV_FAST_SPECIAL_EN
  // Bypass decode for results known at accept time
  always_comb begin
    fast_s     = 1'b0;
    fast_res_s = {XLEN{1'b0}};
    if (b_zero_s) begin
      fast_s     = 1'b1;
      fast_res_s = op[1] ? a : {XLEN{1'b1}};
    end else if (op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}})) begin
      fast_s     = 1'b1;
      fast_res_s = op[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end else if (a_abs_s < b_abs_s) begin
      fast_s     = 1'b1;
      fast_res_s = op[1] ? a : {XLEN{1'b0}};
    end else begin
      fast_s     = 1'b0;
      fast_res_s = {XLEN{1'b0}};
    end
  end
`else
  assign fast_s     = 1'b0;
  assign fast_res_s = {XLEN{1'b0}};
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; flush wins over accept and the output handshake
  always_comb begin
    next_state_s = state_r;
    if (flush) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            next_state_s = fast_s ? DONE : CALC;
          end else begin
            next_state_s = IDLE;
          end
        end
        CALC: begin
          if (cnt_r == 5'd31) begin
            next_state_s = DONE;
          end else begin
            next_state_s = CALC;
          end
        end
        DONE: begin
          if (ready_out) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = DONE;
          end
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r       <= 2'd0;
      div_r      <= {XLEN{1'b0}};
      quo_r      <= {XLEN{1'b0}};
      rem_r      <= {(XLEN+1){1'b0}};
      cnt_r      <= 5'd0;
      sign_q_r   <= 1'b0;
      sign_r_r   <= 1'b0;
      div_zero_r <= 1'b0;
      valid_out  <= 1'b0;
      result     <= {XLEN{1'b0}};
      tag_out    <= {TAG_W{1'b0}};
    end else begin
      valid_out <= (next_state_s == DONE);
      if (flush) begin
        cnt_r <= 5'd0;
      end else if (accept_s) begin
        op_r       <= op;
        tag_out    <= tag_in;
        div_r      <= b_abs_s;
        quo_r      <= a_abs_s;
        rem_r      <= {(XLEN+1){1'b0}};
        cnt_r      <= 5'd0;
        sign_q_r   <= a[XLEN-1] ^ b[XLEN-1];
        sign_r_r   <= a[XLEN-1];
        div_zero_r <= b_zero_s;
        if (fast_s) begin
          result <= fast_res_s;
        end
      end else if (state_r == CALC) begin
        rem_r <= rem_nx_s;
        quo_r <= quo_nx_s;
        cnt_r <= cnt_r + 5'd1;
        if (cnt_r == 5'd31) begin
          result <= calc_res_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic, special cases, latency, backpressure, flush, reset.
// Expected latencies follow DIV_FAST_SPECIAL_EN when the bench is built with it.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset, flush, valid_in, ready_in, valid_out, ready_out;
  logic [1:0]  op;
  logic [31:0] a, b, result;
  logic [4:0]  tag_in, tag_out;

  int checks = 0;
  int failures = 0;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int FAST = 0;
`else
  localparam int FAST = 32;
`endif
  localparam int FULL = 32;

  div_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_in(ready_in),
    .op(op), .a(a), .b(b), .tag_in(tag_in), .valid_out(valid_out), .ready_out(ready_out),
    .result(result), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one op from IDLE; returns with valid_out observed (or timed out)
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; tag_in = t; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = 0;
    while (!valid_out && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] t, input logic [31:0] exp,
                        input int exp_lat);
    int lat;
    issue(o, x, y, t, lat);
    check_val({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({name, "_res"}, result, exp);
    check_val({name, "_tag"}, {27'd0, tag_out}, {27'd0, t});
    @(posedge clk); #1;
    check_val({name, "_idle"}, {30'd0, ready_in, valid_out}, 32'h2);
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] held_res;
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    op = 2'd0; a = 32'd0; b = 32'd0; tag_in = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", {31'd0, valid_out}, 32'd0);
    check_val("rst_result", result, 32'd0);
    check_val("rst_tag", {27'd0, tag_out}, 32'd0);
    check_val("rst_ready", {31'd0, ready_in}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    run_op("udiv_100_7",  2'd0, 32'd100,        32'd7,          5'd1,  32'd14,         FULL);
    run_op("urem_100_7",  2'd2, 32'd100,        32'd7,          5'd2,  32'd2,          FULL);
    run_op("sdiv_m7_2",   2'd1, 32'hFFFFFFF9,   32'd2,          5'd3,  32'hFFFFFFFD,   FULL);
    run_op("srem_m7_2",   2'd3, 32'hFFFFFFF9,   32'd2,          5'd4,  32'hFFFFFFFF,   FULL);
    run_op("srem_7_m2",   2'd3, 32'd7,          32'hFFFFFFFE,   5'd5,  32'd1,          FULL);
    run_op("udiv_5_0",    2'd0, 32'd5,          32'd0,          5'd6,  32'hFFFFFFFF,   FAST);
    run_op("sdiv_m5_0",   2'd1, 32'hFFFFFFFB,   32'd0,          5'd7,  32'hFFFFFFFF,   FAST);
    run_op("urem_5_0",    2'd2, 32'd5,          32'd0,          5'd8,  32'd5,          FAST);
    run_op("srem_m7_0",   2'd3, 32'hFFFFFFF9,   32'd0,          5'd9,  32'hFFFFFFF9,   FAST);
    run_op("sdiv_ovf",    2'd1, 32'h80000000,   32'hFFFFFFFF,   5'd10, 32'h80000000,   FAST);
    run_op("srem_ovf",    2'd3, 32'h80000000,   32'hFFFFFFFF,   5'd11, 32'd0,          FAST);
    run_op("udiv_3_10",   2'd0, 32'd3,          32'd10,         5'd12, 32'd0,          FAST);
    run_op("srem_m3_10",  2'd3, 32'hFFFFFFFD,   32'd10,         5'd13, 32'hFFFFFFFD,   FAST);
    run_op("udiv_big",    2'd0, 32'hFFFFFFFF,   32'd16,         5'd14, 32'h0FFFFFFF,   FULL);

    // Backpressure: result held in DONE while write-back stalls
    ready_out = 1'b0;
    issue(2'd0, 32'd100, 32'd7, 5'd21, lat);
    check_val("bp_lat", 32'(lat), 32'd32);
    held_res = result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("bp_hold", {valid_out, ready_in, 25'd0, tag_out}, {1'b1, 1'b0, 25'd0, 5'd21});
      check_val("bp_res", result, 32'd14);
    end
    @(negedge clk);
    ready_out = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release", {30'd0, ready_in, valid_out}, 32'h2);

    // Flush at iteration 10, accept attempt blocked while flush is high
    @(negedge clk);
    op = 2'd0; a = 32'd1000; b = 32'd3; tag_in = 5'd22; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    valid_in = 1'b1;
    @(posedge clk); #1;
    check_val("flush_idle", {30'd0, ready_in, valid_out}, 32'h2);
    @(posedge clk); #1;
    check_val("flush_noacc", {31'd0, ready_in}, 32'd1);
    @(negedge clk);
    flush = 1'b0; valid_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_out) seen++;
    end
    check_val("flush_novalid", 32'(seen), 32'd0);
    run_op("post_flush", 2'd1, 32'hFFFFFF9C, 32'd7, 5'd23, 32'hFFFFFFF2, FULL);

    // Asynchronous reset mid-CALC clears outputs before any edge
    @(negedge clk);
    op = 2'd2; a = 32'd50; b = 32'd9; tag_in = 5'd24; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_val("arst_out", {valid_out, 26'd0, tag_out}, 32'd0);
    check_val("arst_res", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_reset", 2'd2, 32'd50, 32'd9, 5'd25, 32'd5, FULL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
